// File: rtl/button_step_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_step_encoder_pkg
// Purpose : Shared encodings for the button step encoder and the rotator
//           clock-select stage. The arbiter state encodings and the step
//           direction constants live here so both sides agree on them.
// Contents: c_ST_*  - 2-bit arbiter states (IDLE, HELD_A, HELD_B, LOCK)
//           c_DIR_* - step direction (CW = clk1->clk2->clk3, CCW = reverse)
// Revision: 1.0 - initial release
// ============================================================================
package button_step_encoder_pkg;

    // Arbiter state encodings
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HELD_A = 2'd1;
    localparam logic [1:0] c_ST_HELD_B = 2'd2;
    localparam logic [1:0] c_ST_LOCK   = 2'd3;

    // Step directions; button A steps clockwise, button B counter-clockwise
    localparam logic c_DIR_CW  = 1'b1;
    localparam logic c_DIR_CCW = 1'b0;

endpackage : button_step_encoder_pkg
`default_nettype wire

// File: rtl/button_step_encoder_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : Conditions one asynchronous button pin: 2-FF synchroniser,
//           stability counter, debounced level and a 1-cycle rise pulse.
// Ports   : clk1     in  block clock
//           reset    in  synchronous, active-high
//           i_raw    in  asynchronous button pin, active-high
//           o_level  out debounced level
//           o_rise   out 1-cycle pulse on the cycle the level goes 0->1
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned CNT_W           = 4
) (
    input  logic clk1,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;   // [0] first flop, [1] second flop (synced)
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_synced;

    assign w_synced  = r_sync[1];
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_rise <= 1'b0;
            if (w_synced == r_level) begin
                // Any agreeing sample restarts the stability count.
                r_cnt <= '0;
            end else if (w_cnt_inc == c_DEB_LAST) begin
                // Enough consecutive disagreeing samples: accept the new level.
                r_level <= w_synced;
                r_cnt   <= '0;
                r_rise  <= w_synced;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_step_encoder.sv
`default_nettype none
// ============================================================================
// Module  : button_step_encoder
// Purpose : Turns the raw buttonA/buttonB pins into one-shot step commands
//           (with press-and-hold auto-repeat) for the rotator clock-select
//           stage, offered over a single-entry valid/ready slot.
// Ports   : clk1       in  block clock
//           reset      in  synchronous, active-high
//           btn_a_raw  in  async button A pin (CW request)
//           btn_b_raw  in  async button B pin (CCW request)
//           cmd_valid  out step command pending
//           cmd_dir    out 1 = CW, 0 = CCW; stable while cmd_valid
//           cmd_ready  in  consumer accepts (transfer on valid & ready)
//           a_level    out debounced level of button A
//           b_level    out debounced level of button B
//           overrun    out sticky: a command was dropped on a full slot
// Revision: 1.0 - initial release
// ============================================================================
module button_step_encoder
    import button_step_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned REPEAT_DELAY    = 6,
    parameter int unsigned REPEAT_RATE     = 3,
    parameter int unsigned CNT_W           = 4
) (
    input  logic clk1,
    input  logic reset,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic cmd_valid,
    output logic cmd_dir,
    input  logic cmd_ready,
    output logic a_level,
    output logic b_level,
    output logic overrun
);

    // Reject parameter sets the counters cannot represent.
    if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES >= (2 ** CNT_W)) ||
        (REPEAT_DELAY    < 1) || (REPEAT_DELAY    >= (2 ** CNT_W)) ||
        (REPEAT_RATE     < 1) || (REPEAT_RATE     >= (2 ** CNT_W))) begin : g_bad_params
        $error("button_step_encoder: timing parameters must be in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] c_RPT_DELAY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] c_RPT_RATE  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] c_RPT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_a_level, w_a_rise;
    logic w_b_level, w_b_rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_a (
        .clk1    (clk1),
        .reset   (reset),
        .i_raw   (btn_a_raw),
        .o_level (w_a_level),
        .o_rise  (w_a_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_b (
        .clk1    (clk1),
        .reset   (reset),
        .i_raw   (btn_b_raw),
        .o_level (w_b_level),
        .o_rise  (w_b_rise)
    );

    // ------------------------------------------------------------------
    // Arbiter FSM and repeat counter
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_rpt;
    logic             r_cmd_valid;
    logic             r_cmd_dir;
    logic             r_overrun;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_rpt_nxt;
    logic             w_gen;
    logic             w_gen_dir;

    always_comb begin
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt;
        w_gen       = 1'b0;
        w_gen_dir   = c_DIR_CCW;
        case (r_state)
            c_ST_IDLE: begin
                if (w_a_rise && w_b_rise) begin
                    // Simultaneous presses are ambiguous: issue nothing.
                    w_state_nxt = c_ST_LOCK;
                end else if (w_a_rise && !w_b_level) begin
                    w_gen       = 1'b1;
                    w_gen_dir   = c_DIR_CW;
                    w_rpt_nxt   = c_RPT_DELAY;
                    w_state_nxt = c_ST_HELD_A;
                end else if (w_b_rise && !w_a_level) begin
                    w_gen       = 1'b1;
                    w_gen_dir   = c_DIR_CCW;
                    w_rpt_nxt   = c_RPT_DELAY;
                    w_state_nxt = c_ST_HELD_B;
                end
            end
            c_ST_HELD_A: begin
                if (w_b_level) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (!w_a_level) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_rpt == c_RPT_ONE) begin
                    w_gen     = 1'b1;
                    w_gen_dir = c_DIR_CW;
                    w_rpt_nxt = c_RPT_RATE;
                end else begin
                    w_rpt_nxt = r_rpt - 1'b1;
                end
            end
            c_ST_HELD_B: begin
                if (w_a_level) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (!w_b_level) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_rpt == c_RPT_ONE) begin
                    w_gen     = 1'b1;
                    w_gen_dir = c_DIR_CCW;
                    w_rpt_nxt = c_RPT_RATE;
                end else begin
                    w_rpt_nxt = r_rpt - 1'b1;
                end
            end
            c_ST_LOCK: begin
                // Stay quiet until both buttons are fully released.
                if (!w_a_level && !w_b_level) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers and single-entry output slot
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_rpt       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_dir   <= c_DIR_CCW;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rpt   <= w_rpt_nxt;
            if (w_gen) begin
                if (!r_cmd_valid || cmd_ready) begin
                    // Slot is empty or being drained this cycle: reload it.
                    r_cmd_valid <= 1'b1;
                    r_cmd_dir   <= w_gen_dir;
                end else begin
                    // Slot held by the consumer: keep the pending command.
                    r_overrun <= 1'b1;
                end
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_dir   = r_cmd_dir;
    assign a_level   = w_a_level;
    assign b_level   = w_b_level;
    assign overrun   = r_overrun;

endmodule : button_step_encoder
`default_nettype wire

// File: tb/tb_button_step_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_step_encoder
// Purpose : Self-checking bench for button_step_encoder. A cycle-level
//           behavioural model (press streaks, hold age, slot occupancy) runs
//           alongside the DUT; every output is compared each cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_step_encoder;

    localparam int c_DEB   = 2;
    localparam int c_DELAY = 6;
    localparam int c_RATE  = 3;

    logic clk1 = 1'b0;
    logic reset;
    logic btn_a_raw;
    logic btn_b_raw;
    logic cmd_ready;
    logic cmd_valid;
    logic cmd_dir;
    logic a_level;
    logic b_level;
    logic overrun;

    int n_vectors     = 0;
    int n_miscompares = 0;

    always #5 clk1 = ~clk1;

    button_step_encoder #(
        .DEBOUNCE_CYCLES (c_DEB),
        .REPEAT_DELAY    (c_DELAY),
        .REPEAT_RATE     (c_RATE),
        .CNT_W           (4)
    ) dut (
        .clk1      (clk1),
        .reset     (reset),
        .btn_a_raw (btn_a_raw),
        .btn_b_raw (btn_b_raw),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .a_level   (a_level),
        .b_level   (b_level),
        .overrun   (overrun)
    );

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_HOLD_A, M_HOLD_B, M_BLOCKED} mode_t;

    logic [1:0] m_pipe [2];   // per button: [0] newest sample, [1] seen by debounce
    bit         m_lvl  [2];
    bit         m_rise [2];
    int         m_streak [2]; // consecutive samples disagreeing with the level
    mode_t      m_mode;
    int         m_age;        // cycles since the first command of the current hold
    bit         m_valid;
    bit         m_dir;
    bit         m_ovr;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pipe[i] = 2'b00; m_lvl[i] = 0; m_rise[i] = 0; m_streak[i] = 0;
        end
        m_mode = M_IDLE; m_age = 0; m_valid = 0; m_dir = 0; m_ovr = 0;
    end

    always @(posedge clk1) begin
        bit emit;
        bit edir;
        bit raw;
        int h;
        emit = 0;
        edir = 0;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_pipe[i] = 2'b00; m_lvl[i] = 0; m_rise[i] = 0; m_streak[i] = 0;
            end
            m_mode = M_IDLE; m_age = 0; m_valid = 0; m_dir = 0; m_ovr = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_rise[0] && m_rise[1]) m_mode = M_BLOCKED;
                    else if (m_rise[0] && !m_lvl[1]) begin
                        emit = 1; edir = 1; m_mode = M_HOLD_A; m_age = 0;
                    end else if (m_rise[1] && !m_lvl[0]) begin
                        emit = 1; edir = 0; m_mode = M_HOLD_B; m_age = 0;
                    end
                end
                M_HOLD_A, M_HOLD_B: begin
                    h = (m_mode == M_HOLD_A) ? 0 : 1;
                    if (m_lvl[1-h]) m_mode = M_BLOCKED;
                    else if (!m_lvl[h]) m_mode = M_IDLE;
                    else begin
                        m_age++;
                        if (m_age == c_DELAY ||
                            (m_age > c_DELAY && ((m_age - c_DELAY) % c_RATE) == 0)) begin
                            emit = 1; edir = (h == 0);
                        end
                    end
                end
                default: begin
                    if (!m_lvl[0] && !m_lvl[1]) m_mode = M_IDLE;
                end
            endcase

            if (emit) begin
                if (!m_valid || cmd_ready) begin
                    m_valid = 1; m_dir = edir;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && cmd_ready) begin
                m_valid = 0;
            end

            for (int i = 0; i < 2; i++) begin
                raw = (i == 0) ? btn_a_raw : btn_b_raw;
                m_rise[i] = 0;
                if (m_pipe[i][1] == m_lvl[i]) m_streak[i] = 0;
                else begin
                    m_streak[i]++;
                    if (m_streak[i] == c_DEB) begin
                        m_lvl[i]    = m_pipe[i][1];
                        m_streak[i] = 0;
                        m_rise[i]   = m_lvl[i];
                    end
                end
                m_pipe[i] = {m_pipe[i][0], raw};
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic obs, input logic exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", tag, $time, obs, exp);
        end
    endtask

    // One clock: compare all outputs on the falling edge, then drive the
    // inputs for the next rising edge.
    task automatic step(input bit a, input bit b, input bit rdy, input bit rst);
        @(negedge clk1);
        check("cmd_valid", cmd_valid, m_valid);
        check("cmd_dir",   cmd_dir,   m_dir);
        check("a_level",   a_level,   m_lvl[0]);
        check("b_level",   b_level,   m_lvl[1]);
        check("overrun",   overrun,   m_ovr);
        btn_a_raw = a;
        btn_b_raw = b;
        cmd_ready = rdy;
        reset     = rst;
    endtask

    task automatic hold(input bit a, input bit b, input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(a, b, rdy, 1'b0);
    endtask

    int cmd_count;
    always @(posedge clk1) if (!reset && cmd_valid && cmd_ready) cmd_count++;

    initial begin
        int na, nb, len;
        reset = 1'b1; btn_a_raw = 1'b0; btn_b_raw = 1'b0; cmd_ready = 1'b1;
        cmd_count = 0;

        hold(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        hold(0, 0, 1, 4);

        // Single A tap
        hold(1, 0, 1, 10);
        hold(0, 0, 1, 10);

        // Bouncing B, then a clean hold
        step(0, 1, 1, 0); step(0, 0, 1, 0); step(0, 1, 1, 0); step(0, 0, 1, 0);
        hold(0, 1, 1, 10);
        hold(0, 0, 1, 10);

        // Hold A with auto-repeat
        hold(1, 0, 1, 20);
        hold(0, 0, 1, 12);

        // B joins 3 cycles after A, then a B tap
        hold(1, 0, 1, 3);
        hold(1, 1, 1, 12);
        hold(0, 0, 1, 10);
        hold(0, 1, 1, 6);
        hold(0, 0, 1, 8);

        // Both pressed together
        hold(1, 1, 1, 12);
        hold(0, 0, 1, 8);

        // Backpressure: A tap then B tap with the consumer stalled
        hold(1, 0, 0, 6);
        hold(0, 0, 0, 6);
        hold(0, 1, 0, 6);
        hold(0, 0, 0, 6);
        hold(0, 0, 1, 3);
        hold(0, 0, 0, 3);

        // Reset mid-hold with a command pending
        hold(1, 0, 0, 14);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        hold(0, 0, 1, 10);
        hold(1, 0, 1, 8);
        hold(0, 0, 1, 8);

        // Randomised segments
        for (int s = 0; s < 300; s++) begin
            na  = $urandom_range(0, 3);
            nb  = $urandom_range(0, 5);
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                step((na == 3) ? bit'($urandom_range(0, 1)) : bit'(na != 0),
                     (nb >= 4) ? bit'($urandom_range(0, 1)) : bit'(nb == 1),
                     bit'($urandom_range(0, 3) != 0),
                     bit'($urandom_range(0, 150) == 0));
            end
        end
        hold(0, 0, 1, 10);

        if (cmd_count == 0) begin
            n_vectors++;
            n_miscompares++;
            $display("FAIL cmd_traffic: got %0d transfers, expected at least 1", cmd_count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_button_step_encoder
`default_nettype wire
